input_debouncer: RTL and testbench

Front-end conditioning stage for the switch inputs that feed the combinational A/B/C logic on `ui_in[2:0]`. Each raw pad input passes through a synchronizer and a per-channel stability counter. Only a level held steady for a programmable number of cycles reaches the downstream logic. One-cycle rise/fall strobes are also produced so later sequential stages can react to clean edges.

---
 rtl/input_debouncer_pkg.sv | 9 +
 rtl/debounce_channel.sv | 73 +++++++
 rtl/input_debouncer.sv | 39 +++
 tb/tb_input_debouncer.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/input_debouncer_pkg.sv
// Shared defaults and channel indices for the switch-input debouncer.
package input_debouncer_pkg;
   localparam int DEF_SYNC_STAGES     = 2;
   localparam int DEF_DEBOUNCE_CYCLES = 16;

   localparam int CH_A = 0;
   localparam int CH_B = 1;
   localparam int CH_C = 2;
endpackage

// File: rtl/debounce_channel.sv
// One debounced channel: synchronizer, stability counter, clean level and
// optional edge pulses (built only with INPUT_DEBOUNCER_EDGE_EN defined).
module debounce_channel
   import input_debouncer_pkg::*;
#(
   parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
   input  logic clk,
   input  logic rst,
   input  logic ena,
   input  logic raw_in,
   output logic clean_out,
   output logic rise_out,
   output logic fall_out
);
   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   clean_q, clean_d;
   logic                   sync_bit;

   always_comb begin
      sync_bit = sync_q[SYNC_STAGES-1];
      sync_d   = {sync_q[SYNC_STAGES-2:0], raw_in};
      cnt_d    = '0;
      clean_d  = clean_q;
      // Counter only runs while the synced level disagrees with the clean level.
      if (ena && (sync_bit != clean_q)) begin
         if (cnt_q == CNT_MAX) begin
            clean_d = sync_bit;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q  <= '0;
         cnt_q   <= '0;
         clean_q <= 1'b0;
      end else begin
         sync_q  <= sync_d;
         cnt_q   <= cnt_d;
         clean_q <= clean_d;
      end
   end

   assign clean_out = clean_q;

`ifdef INPUT_DEBOUNCER_EDGE_EN
   logic rise_q, fall_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         rise_q <= 1'b0;
         fall_q <= 1'b0;
      end else begin
         rise_q <= clean_d & ~clean_q;
         fall_q <= ~clean_d & clean_q;
      end
   end

   assign rise_out = rise_q;
   assign fall_out = fall_q;
`else
   assign rise_out = 1'b0;
   assign fall_out = 1'b0;
`endif
endmodule

// File: rtl/input_debouncer.sv
// Debouncer front end for ui_in[2:0]: fans out per-channel debouncers and
// reduces edge pulses to changed_out (pulses need INPUT_DEBOUNCER_EDGE_EN).
module input_debouncer
   import input_debouncer_pkg::*;
#(
   parameter int CHANNELS        = 3,
   parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                ena,
   input  logic [CHANNELS-1:0] raw_in,
   output logic [CHANNELS-1:0] clean_out,
   output logic [CHANNELS-1:0] rise_out,
   output logic [CHANNELS-1:0] fall_out,
   output logic                changed_out
);
   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      debounce_channel #(
         .SYNC_STAGES     (SYNC_STAGES),
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_ch (
         .clk       (clk),
         .rst       (rst),
         .ena       (ena),
         .raw_in    (raw_in[i]),
         .clean_out (clean_out[i]),
         .rise_out  (rise_out[i]),
         .fall_out  (fall_out[i])
      );
   end

`ifdef INPUT_DEBOUNCER_EDGE_EN
   assign changed_out = |{rise_out, fall_out};
`else
   assign changed_out = 1'b0;
`endif
endmodule

// File: tb/tb_input_debouncer.sv
// Scoreboard bench for input_debouncer with SYNC_STAGES=2, DEBOUNCE_CYCLES=4.
module tb_input_debouncer;
   import input_debouncer_pkg::*;

   localparam int D = 4;
`ifdef INPUT_DEBOUNCER_EDGE_EN
   localparam int EXP_P = 1;
`else
   localparam int EXP_P = 0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       ena = 1'b1;
   logic [2:0] raw_in = 3'b000;
   logic [2:0] clean_out, rise_out, fall_out;
   logic       changed_out;

   input_debouncer #(
      .CHANNELS        (3),
      .SYNC_STAGES     (2),
      .DEBOUNCE_CYCLES (D)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .ena         (ena),
      .raw_in      (raw_in),
      .clean_out   (clean_out),
      .rise_out    (rise_out),
      .fall_out    (fall_out),
      .changed_out (changed_out)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0] clean;
      logic [2:0] rise;
      logic [2:0] fall;
      logic       chg;
   } exp_t;

   exp_t sb[$];
   int   n_vec = 0;
   int   n_err = 0;

   // model: two sync stages, run length of disagreeing samples, clean level
   logic [2:0] m_s0 = '0, m_s1 = '0, m_clean = '0, m_rise = '0, m_fall = '0;
   int         m_run [3] = '{0, 0, 0};

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_vec++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
      end
   endtask

   task automatic model(input logic r, input logic e, input logic [2:0] raw);
      exp_t x;
      if (r) begin
         m_s0 = '0; m_s1 = '0; m_clean = '0; m_rise = '0; m_fall = '0;
         for (int c = 0; c < 3; c++) m_run[c] = 0;
      end else begin
         m_rise = '0; m_fall = '0;
         for (int c = 0; c < 3; c++) begin
            if (e && (m_s1[c] != m_clean[c])) begin
               m_run[c]++;
               if (m_run[c] == D) begin
                  m_run[c] = 0;
                  if (m_s1[c]) m_rise[c] = 1'b1;
                  else         m_fall[c] = 1'b1;
                  m_clean[c] = m_s1[c];
               end
            end else begin
               m_run[c] = 0;
            end
         end
         m_s1 = m_s0;
         m_s0 = raw;
      end
      x.clean = m_clean;
      x.rise  = (EXP_P != 0) ? m_rise : 3'b000;
      x.fall  = (EXP_P != 0) ? m_fall : 3'b000;
      x.chg   = (EXP_P != 0) ? |{m_rise, m_fall} : 1'b0;
      sb.push_back(x);
   endtask

   task automatic step(input logic r, input logic e, input logic [2:0] raw);
      exp_t x;
      rst = r; ena = e; raw_in = raw;
      model(r, e, raw);
      @(posedge clk);
      #1;
      x = sb.pop_front();
      chk("clean", 32'(clean_out), 32'(x.clean));
      chk("rise", 32'(rise_out), 32'(x.rise));
      chk("fall", 32'(fall_out), 32'(x.fall));
      chk("changed", 32'(changed_out), 32'(x.chg));
   endtask

   // hold inputs; return first edge where masked clean equals want (0 = never)
   task automatic measure(input logic e, input logic [2:0] raw, input logic [2:0] mask,
                          input logic [2:0] want, input int budget,
                          output int lat, output int rises, output int falls);
      lat = 0; rises = 0; falls = 0;
      for (int i = 1; i <= budget; i++) begin
         step(1'b0, e, raw);
         if (lat == 0 && ((clean_out & mask) == want)) lat = i;
         rises += $countones(rise_out & mask);
         falls += $countones(fall_out & mask);
      end
   endtask

   int lat, rises, falls;

   initial begin
      // reset with all inputs high, then full latency on every channel
      step(1'b1, 1'b1, 3'b111);
      chk("rst_clean", 32'(clean_out), 32'h0);
      step(1'b1, 1'b1, 3'b111);
      measure(1'b1, 3'b111, 3'b111, 3'b111, 12, lat, rises, falls);
      chk("all_lat", 32'(lat), 32'd6);
      chk("all_rises", 32'(rises), 32'(3 * EXP_P));

      // bouncing then steady high on A
      step(1'b1, 1'b1, 3'b000);
      for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 3'b000);
      step(1'b0, 1'b1, 3'b001);
      step(1'b0, 1'b1, 3'b000);
      step(1'b0, 1'b1, 3'b001);
      step(1'b0, 1'b1, 3'b000);
      chk("bounce_hold", 32'(clean_out), 32'h0);
      measure(1'b1, 3'b001, 3'b001, 3'b001, 12, lat, rises, falls);
      chk("bounce_lat", 32'(lat), 32'd6);
      chk("bounce_rises", 32'(rises), 32'(EXP_P));

      // 3-cycle low glitch must not reach clean_out
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 3'b000);
      measure(1'b1, 3'b001, 3'b001, 3'b000, 12, lat, rises, falls);
      chk("glitch_lat", 32'(lat), 32'd0);
      chk("glitch_falls", 32'(falls), 32'd0);

      // fall on A
      measure(1'b1, 3'b000, 3'b001, 3'b000, 12, lat, rises, falls);
      chk("fall_lat", 32'(lat), 32'd6);
      chk("fall_falls", 32'(falls), 32'(EXP_P));

      // enable low freezes B, then the already-filled chain needs D edges
      for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 3'b010);
      chk("ena_frozen", 32'(clean_out[CH_B]), 32'h0);
      measure(1'b1, 3'b010, 3'b010, 3'b010, 12, lat, rises, falls);
      chk("ena_lat", 32'(lat), 32'(D));

      // reset in the middle of a count
      step(1'b1, 1'b1, 3'b000);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 3'b000);
      for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 3'b111);
      step(1'b1, 1'b1, 3'b111);
      chk("mid_rst_out", 32'({clean_out, rise_out, fall_out, changed_out}), 32'h0);
      measure(1'b1, 3'b111, 3'b111, 3'b111, 12, lat, rises, falls);
      chk("mid_rst_lat", 32'(lat), 32'd6);
      chk("mid_rst_rises", 32'(rises), 32'(3 * EXP_P));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
